sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 19 +
 rtl/sync_fifo_param_if.sv | 38 +++
 rtl/fifo_ram.sv | 40 ++++
 rtl/sync_fifo_param.sv | 99 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, pointer-width helper and status bundle for the parameterised sync FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Index bits plus one wrap bit so full and empty stay distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return unsigned'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO client-side bus: push/pop requests, read data and status/error flags.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) ();

  localparam int unsigned PW = ptr_w(DEPTH);

  logic              push;
  logic [DATA_W-1:0] wdata;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              push_ack;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [PW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, wdata, pop, clr_err,
    input  rdata, rvalid, push_ack, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, wdata, pop, clr_err,
    output rdata, rvalid, push_ack, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write; async read with SYNC_FIFO_FWFT_EN,
// otherwise a registered read captured on i_re.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic w_unused;
  assign w_unused = &{1'b0, rst, i_re};
  assign o_rdata  = r_mem[i_raddr];
`else
  logic [DATA_W-1:0] r_rdata;

  // Old word is read when a full FIFO overwrites the head slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO control: pointers, count, status and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]     r_wptr, r_rptr, r_count;
  logic [PW-1:0]     w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  fifo_status_t      r_stat;
  logic              r_push_ack, r_ovf, r_unf;
  logic              w_pop_acc, w_push_acc, w_ovf_evt, w_unf_evt;
  logic [DATA_W-1:0] w_ram_rdata;

  // A pop frees a slot in the same cycle, so push is allowed on full when pop is taken.
  always_comb begin
    w_pop_acc   = bus.pop && !r_stat.empty;
    w_push_acc  = bus.push && (!r_stat.full || w_pop_acc);
    w_ovf_evt   = bus.push && !w_push_acc;
    w_unf_evt   = bus.pop && r_stat.empty;
    w_wptr_nxt  = r_wptr + PW'(w_push_acc);
    w_rptr_nxt  = r_rptr + PW'(w_pop_acc);
    w_count_nxt = w_wptr_nxt - w_rptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_stat     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      r_push_ack <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_wptr              <= w_wptr_nxt;
      r_rptr              <= w_rptr_nxt;
      r_count             <= w_count_nxt;
      r_stat.full         <= (w_count_nxt == PW'(DEPTH));
      r_stat.empty        <= (w_count_nxt == '0);
      r_stat.almost_full  <= (w_count_nxt >= PW'(AF_LEVEL));
      r_stat.almost_empty <= (w_count_nxt <= PW'(AE_LEVEL));
      r_push_ack          <= w_push_acc;
      // A new error in the clearing cycle keeps the flag set.
      r_ovf               <= w_ovf_evt || (r_ovf && !bus.clr_err);
      r_unf               <= w_unf_evt || (r_unf && !bus.clr_err);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_push_acc && !rst),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (bus.wdata),
    .i_re    (w_pop_acc),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rvalid = !r_stat.empty;
  assign bus.rdata  = r_stat.empty ? '0 : w_ram_rdata;
`else
  logic r_rvalid;

  always_ff @(posedge clk) begin
    if (rst) r_rvalid <= 1'b0;
    else     r_rvalid <= w_pop_acc;
  end

  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = w_ram_rdata;
`endif

  assign bus.push_ack     = r_push_ack;
  assign bus.full         = r_stat.full;
  assign bus.empty        = r_stat.empty;
  assign bus.almost_full  = r_stat.almost_full;
  assign bus.almost_empty = r_stat.almost_empty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule
